// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and data memory.
// The stage drives the request side (master); the memory drives read data and the ack pulse (slave).
interface mem_access_stage_if #(
    parameter int unsigned DW = 16
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores over the dmem req/ack bus, stalls upstream
// while an access is outstanding, aborts after MAX_WAIT cycles, and registers the write-back bundle.
module mem_access_stage #(
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_acs_in,
    input  logic                 rd_wr_ena_in,
    input  logic [DW-1:0]        mem_adrs_in,
    input  logic [DW-1:0]        alu_out_in,
    input  logic [DW-1:0]        store_data_in,
    input  logic                 write_b_f_in,
    input  logic [2:0]           rf_wa_in,
    input  logic [DW-1:0]        pc_in,
    mem_access_stage_if.master   dmem,
    output logic                 stall,
    output logic [DW-1:0]        wb_data,
    output logic                 wb_en,
    output logic [2:0]           wb_addr,
    output logic [DW-1:0]        pc_mem,
    output logic                 mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          wb_en_q, wb_en_d;
    logic [2:0]    wb_addr_q, wb_addr_d;
    logic [DW-1:0] pc_mem_q, pc_mem_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            pc_mem_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            pc_mem_q  <= pc_mem_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (mem_acs_in) state_d = S_WAIT;
            S_WAIT:  if (dmem.dmem_ack || cnt_q == LAST_WAIT) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        wb_en_d   = wb_en_q;
        wb_addr_d = wb_addr_q;
        pc_mem_d  = pc_mem_q;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_acs_in) begin
                    req_d   = 1'b1;
                    we_d    = rd_wr_ena_in;
                    addr_d  = mem_adrs_in;
                    wdata_d = store_data_in;
                    wb_en_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    wb_data_d = alu_out_in;
                    wb_en_d   = write_b_f_in;
                    wb_addr_d = rf_wa_in;
                    pc_mem_d  = pc_in;
                end
            end
            S_WAIT: begin
                if (dmem.dmem_ack) begin
                    req_d     = 1'b0;
                    wb_addr_d = rf_wa_in;
                    pc_mem_d  = pc_in;
                    if (we_q) begin
                        wb_en_d = 1'b0;
                    end else begin
                        wb_data_d = dmem.dmem_rdata;
                        wb_en_d   = write_b_f_in;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    req_d   = 1'b0;
                    wb_en_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: wb_en_d = 1'b0;
            default: ;
        endcase
    end

    // Gated by reset so stall drops together with the registered outputs while reset is held.
    always_comb begin
        stall = reset && ((state_q == S_IDLE && mem_acs_in) || state_q == S_WAIT);
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_data         = wb_data_q;
    assign wb_en           = wb_en_q;
    assign wb_addr         = wb_addr_q;
    assign pc_mem          = pc_mem_q;
    assign mem_err         = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage: each task drives one scenario and checks inline.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_acs_in, rd_wr_ena_in, write_b_f_in;
    logic [15:0] mem_adrs_in, alu_out_in, store_data_in, pc_in;
    logic [2:0]  rf_wa_in;
    logic        stall, wb_en, mem_err;
    logic [15:0] wb_data, pc_mem;
    logic [2:0]  wb_addr;
    int          errors = 0;
    int          checks = 0;

    mem_access_stage_if #(.DW(16)) bus ();

    mem_access_stage #(.DW(16), .MAX_WAIT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_acs_in    (mem_acs_in),
        .rd_wr_ena_in  (rd_wr_ena_in),
        .mem_adrs_in   (mem_adrs_in),
        .alu_out_in    (alu_out_in),
        .store_data_in (store_data_in),
        .write_b_f_in  (write_b_f_in),
        .rf_wa_in      (rf_wa_in),
        .pc_in         (pc_in),
        .dmem          (bus),
        .stall         (stall),
        .wb_data       (wb_data),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .pc_mem        (pc_mem),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic acs, input logic we, input logic [15:0] adrs,
                             input logic [15:0] alu, input logic [15:0] sd, input logic wbf,
                             input logic [2:0] wa, input logic [15:0] pc);
        mem_acs_in = acs; rd_wr_ena_in = we; mem_adrs_in = adrs; alu_out_in = alu;
        store_data_in = sd; write_b_f_in = wbf; rf_wa_in = wa; pc_in = pc;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        set_instr(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        step();
        checks++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== 34'h0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0",
                               {bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata});
        end
        checks++;
        if ({stall, wb_data, wb_en, wb_addr, pc_mem, mem_err} !== 38'h0) begin
            errors++; $display("FAIL reset_outs: got %h expected 0",
                               {stall, wb_data, wb_en, wb_addr, pc_mem, mem_err});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_nonmem();
        set_instr(1'b0, 1'b0, 16'h0, 16'h1234, 16'h0, 1'b1, 3'd3, 16'h0010);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %b expected 0", stall); end
        step();
        checks++;
        if ({wb_data, wb_en, wb_addr, pc_mem} !== {16'h1234, 1'b1, 3'd3, 16'h0010}) begin
            errors++; $display("FAIL nonmem_wb: got %h/%b/%0d/%h expected 1234/1/3/0010",
                               wb_data, wb_en, wb_addr, pc_mem);
        end
        checks++;
        if (stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++; $display("FAIL nonmem_nostall: stall=%b req=%b expected 0/0", stall, bus.dmem_req);
        end
        set_instr(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        step();
    endtask

    task automatic test_load_wait2();
        int n_req = 0;
        int n_stall = 0;
        set_instr(1'b1, 1'b0, 16'h0040, 16'h9999, 16'h0, 1'b1, 3'd5, 16'h0020);
        bus.dmem_rdata = 16'hBEEF;
        for (int c = 0; c < 4; c++) begin
            if (stall === 1'b1) n_stall++;
            if (bus.dmem_req === 1'b1) n_req++;
            if (c == 1) begin
                checks++;
                if ({bus.dmem_addr, bus.dmem_we} !== {16'h0040, 1'b0}) begin
                    errors++; $display("FAIL load_bus: got addr=%h we=%b expected 0040/0",
                                       bus.dmem_addr, bus.dmem_we);
                end
            end
            if (c == 3) bus.dmem_ack = 1'b1;
            step();
        end
        bus.dmem_ack = 1'b0;
        checks++;
        if (n_req !== 3) begin errors++; $display("FAIL load_req_cycles: got %0d expected 3", n_req); end
        checks++;
        if (n_stall !== 4) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 4", n_stall); end
        checks++;
        if ({wb_data, wb_en, wb_addr, pc_mem, bus.dmem_req, stall} !==
            {16'hBEEF, 1'b1, 3'd5, 16'h0020, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_wb: got %h/%b/%0d/%h req=%b stall=%b expected BEEF/1/5/0020 0/0",
                               wb_data, wb_en, wb_addr, pc_mem, bus.dmem_req, stall);
        end
        step();
        set_instr(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        checks++;
        if (wb_en !== 1'b0) begin errors++; $display("FAIL load_wb_pulse: got %b expected 0", wb_en); end
        step();
    endtask

    task automatic test_store_zero_wait();
        set_instr(1'b1, 1'b1, 16'h0020, 16'h7777, 16'h00FF, 1'b1, 3'd6, 16'h0040);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL store_stall0: got %b expected 1", stall); end
        step();
        checks++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, stall} !==
            {1'b1, 1'b1, 16'h0020, 16'h00FF, 1'b1}) begin
            errors++; $display("FAIL store_bus: got req=%b we=%b addr=%h wdata=%h stall=%b expected 1/1/0020/00FF/1",
                               bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, stall);
        end
        bus.dmem_ack = 1'b1;
        step();
        bus.dmem_ack = 1'b0;
        checks++;
        if ({wb_en, stall, bus.dmem_req} !== 3'b000) begin
            errors++; $display("FAIL store_done: got wb_en=%b stall=%b req=%b expected 0/0/0",
                               wb_en, stall, bus.dmem_req);
        end
        step();
        set_instr(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        checks++;
        if (wb_en !== 1'b0) begin errors++; $display("FAIL store_wb_en: got %b expected 0", wb_en); end
        step();
    endtask

    task automatic test_timeout();
        int n_req = 0;
        set_instr(1'b1, 1'b0, 16'h0080, 16'h0, 16'h0, 1'b1, 3'd2, 16'h0050);
        for (int c = 0; c < 40 && !(c > 0 && bus.dmem_req === 1'b0); c++) begin
            step();
            if (bus.dmem_req === 1'b1) n_req++;
        end
        checks++;
        if (n_req !== 15) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 15", n_req); end
        checks++;
        if ({mem_err, wb_en, stall} !== 3'b100) begin
            errors++; $display("FAIL timeout_flags: got err=%b wb_en=%b stall=%b expected 1/0/0",
                               mem_err, wb_en, stall);
        end
        step();
        set_instr(1'b0, 1'b0, 16'h0, 16'hA5A5, 16'h0, 1'b1, 3'd1, 16'h0052);
        step();
        checks++;
        if ({wb_data, wb_en, mem_err} !== {16'hA5A5, 1'b1, 1'b1}) begin
            errors++; $display("FAIL timeout_continue: got %h/%b err=%b expected A5A5/1 err=1",
                               wb_data, wb_en, mem_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        set_instr(1'b1, 1'b0, 16'h0100, 16'h0, 16'h0, 1'b1, 3'd7, 16'h0060);
        step();
        step();
        checks++;
        if ({bus.dmem_req, stall, mem_err} !== 3'b111) begin
            errors++; $display("FAIL rst_pre: got req=%b stall=%b err=%b expected 1/1/1",
                               bus.dmem_req, stall, mem_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.dmem_req, stall, wb_en, mem_err} !== 4'b0000) begin
            errors++; $display("FAIL rst_async: got req=%b stall=%b wb_en=%b err=%b expected 0/0/0/0",
                               bus.dmem_req, stall, wb_en, mem_err);
        end
        step();
        set_instr(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        reset = 1'b1;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'hDEAD;
        step();
        bus.dmem_ack = 1'b0;
        checks++;
        if ({bus.dmem_req, stall, wb_en, mem_err, wb_data} !== {4'b0000, 16'h0000}) begin
            errors++; $display("FAIL rst_spurious_ack: got req=%b stall=%b wb_en=%b err=%b data=%h expected 0/0/0/0/0000",
                               bus.dmem_req, stall, wb_en, mem_err, wb_data);
        end
    endtask

    task automatic test_back_to_back();
        set_instr(1'b1, 1'b0, 16'h0200, 16'h0, 16'h0, 1'b1, 3'd2, 16'h0030);
        step();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'hCAFE;
        step();
        bus.dmem_ack = 1'b0;
        checks++;
        if ({wb_data, wb_en, wb_addr, pc_mem, bus.dmem_req} !== {16'hCAFE, 1'b1, 3'd2, 16'h0030, 1'b0}) begin
            errors++; $display("FAIL b2b_load: got %h/%b/%0d/%h req=%b expected CAFE/1/2/0030 req=0",
                               wb_data, wb_en, wb_addr, pc_mem, bus.dmem_req);
        end
        step();
        set_instr(1'b0, 1'b0, 16'h0, 16'h5555, 16'h0, 1'b1, 3'd4, 16'h0032);
        checks++;
        if ({wb_en, bus.dmem_req, stall} !== 3'b000) begin
            errors++; $display("FAIL b2b_gap: got wb_en=%b req=%b stall=%b expected 0/0/0",
                               wb_en, bus.dmem_req, stall);
        end
        step();
        checks++;
        if ({wb_data, wb_en, wb_addr, pc_mem} !== {16'h5555, 1'b1, 3'd4, 16'h0032}) begin
            errors++; $display("FAIL b2b_nonmem: got %h/%b/%0d/%h expected 5555/1/4/0032",
                               wb_data, wb_en, wb_addr, pc_mem);
        end
        set_instr(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
        step();
        checks++;
        if (wb_en !== 1'b0) begin errors++; $display("FAIL b2b_end: got wb_en=%b expected 0", wb_en); end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_wait2();
        test_store_zero_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the 6-stage pipeline; consumes the registered memory-request bundle produced by the execute stage.
- Issues the load/store to data memory over a req/ack handshake and stalls upstream while the access is outstanding.
- Delivers the write-back bundle (data, enable, register address, PC) to the write-back stage.

Parameters:
- DW, 16, data/address width
- MAX_WAIT, 15, WAIT-state cycles without dmem_ack before abort; legal range 1..255

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- mem_acs_in  in  1  instruction needs data memory
- rd_wr_ena_in  in  1  1 = store (write), 0 = load (read)
- mem_adrs_in  in  DW  data memory address
- alu_out_in  in  DW  ALU result; pass-through data for non-memory instructions
- store_data_in  in  DW  store data
- write_b_f_in  in  1  instruction writes the register file
- rf_wa_in  in  3  destination register
- pc_in  in  DW  instruction PC
- dmem_req  out  1  request valid, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  DW  registered
- dmem_wdata  out  DW  registered
- dmem_rdata  in  DW  read data, valid when dmem_ack = 1
- dmem_ack  in  1  one-cycle completion pulse
- stall  out  1  combinational; upstream holds all inputs while 1
- wb_data  out  DW  write-back data
- wb_en  out  1  register-file write enable
- wb_addr  out  3  write-back register
- pc_mem  out  DW  PC of the instruction in wb_*
- mem_err  out  1  sticky access-timeout flag

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; every output 0, including dmem_req (dropped immediately, even mid-access); wait counter 0; mem_err 0.
- States: IDLE, WAIT, DONE.
- IDLE with mem_acs_in = 0:
  - stall = 0.
  - Next edge: wb_data <= alu_out_in, wb_en <= write_b_f_in, wb_addr <= rf_wa_in, pc_mem <= pc_in.
  - Latency is 1 cycle.
- IDLE with mem_acs_in = 1:
  - stall = 1 (combinational) in this cycle.
  - Next edge: dmem_req <= 1, dmem_we <= rd_wr_ena_in, dmem_addr <= mem_adrs_in, dmem_wdata <= store_data_in; wb_en <= 0 (bubble); counter <= 0; go to WAIT.
- WAIT:
  - stall = 1; dmem_req and the bus stay stable until ack.
  - dmem_ack = 1:
    - dmem_req <= 0.
    - Load: wb_data <= dmem_rdata, wb_en <= write_b_f_in.
    - Store: wb_en <= 0.
    - wb_addr <= rf_wa_in, pc_mem <= pc_in; go to DONE.
  - No ack and counter = MAX_WAIT-1: dmem_req <= 0, wb_en <= 0, mem_err <= 1; go to DONE.
  - Otherwise counter increments.
- DONE:
  - stall = 0, so upstream advances at the end of this cycle.
  - mem_acs_in is ignored, because the inputs still hold the finished instruction.
  - Next edge: wb_en <= 0, then IDLE. A load write-back is therefore a single-cycle wb_en pulse.
- dmem_ack in IDLE/DONE: ignored.
- Ack on the first WAIT cycle (zero wait): stall high for 2 cycles; wb valid 2 edges after the instruction is presented.
- Stall cycles per memory instruction = 1 + WAIT cycles.
- mem_err: sticky, cleared only by reset; the pipeline continues after an abort.
- Store wb_data: undefined, because wb_en = 0.
- Back-to-back memory instructions: each passes through IDLE → WAIT → DONE; there is no overlap.
- dmem_req high for a given access only during the WAIT state of that access.

Test Plan:
1. Non-memory: alu_out_in = 16'h1234, write_b_f_in = 1, rf_wa_in = 3, pc_in = 16'h0010 → one edge later wb_data = 1234, wb_en = 1, wb_addr = 3, pc_mem = 0010; stall never 1.
2. Load, ack after 2 WAIT cycles: mem_adrs_in = 16'h0040, dmem_rdata = 16'hBEEF → dmem_req high for 3 cycles with dmem_addr = 0040 and dmem_we = 0; stall high 4 cycles; wb_data = BEEF and wb_en pulses for 1 cycle; wb_addr correct.
3. Store with immediate ack: rd_wr_ena_in = 1, store_data_in = 16'h00FF, mem_adrs_in = 16'h0020 → dmem_we = 1, dmem_wdata = 00FF, dmem_addr = 0020; wb_en stays 0; stall high 2 cycles.
4. Timeout, MAX_WAIT = 15, no ack → dmem_req drops after 15 WAIT cycles; mem_err = 1 and stays 1 through later instructions; wb_en = 0.
5. reset asserted during WAIT → dmem_req, stall, wb_en and mem_err go to 0 immediately; state IDLE; a spurious ack afterwards is ignored.
6. Load immediately followed by a non-memory instruction → exactly one wb_en pulse for each instruction, in order; no duplicated request during DONE.
